// File: rtl/butterfly_pipe.sv
// Three-stage radix-2 FFT butterfly (DIT or DIF per beat) with round-half-up,
// optional divide-by-2, output saturation and a sticky saturation flag.
//
// Handshake: a beat moves into the pipe when i_valid & o_in_ready, and out of it
// when o_valid & i_ready. A single enable (~o_valid | i_ready) advances or freezes
// all three stages together.
module butterfly_pipe #(
    parameter int NBD = 8,
    parameter int NBT = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_valid,
    output logic           o_in_ready,
    input  logic           i_mode,
    input  logic           i_scale,
    input  logic [NBD-1:0] i_x_real,
    input  logic [NBD-1:0] i_x_imag,
    input  logic [NBD-1:0] i_y_real,
    input  logic [NBD-1:0] i_y_imag,
    input  logic [NBT-1:0] i_twiddle_real,
    input  logic [NBT-1:0] i_twiddle_imag,
    output logic           o_valid,
    input  logic           i_ready,
    output logic [NBD-1:0] o_x_real,
    output logic [NBD-1:0] o_x_imag,
    output logic [NBD-1:0] o_y_real,
    output logic [NBD-1:0] o_y_imag,
    output logic           o_sat,
    output logic           o_sat_sticky,
    input  logic           i_sat_clr
);

    localparam int WI = NBD + 3;
    localparam int WP = WI + NBT + 1;
    localparam logic signed [WP-1:0] RND  = WP'(2 ** (NBT - 2));
    localparam logic signed [WI-1:0] ONE  = WI'(1);
    localparam logic signed [WI-1:0] MAXV = WI'(2 ** (NBD - 1) - 1);
    localparam logic signed [WI-1:0] MINV = WI'(-(2 ** (NBD - 1)));

    function automatic logic [WI-1:0] ext_d(input logic [NBD-1:0] v);
        return {{(WI - NBD){v[NBD-1]}}, v};
    endfunction

    function automatic logic signed [WP-1:0] ext_p(input logic [WI-1:0] v);
        return {{(WP - WI){v[WI-1]}}, v};
    endfunction

    function automatic logic signed [WP-1:0] ext_w(input logic [NBT-1:0] v);
        return {{(WP - NBT){v[NBT-1]}}, v};
    endfunction

    // One component of a complex product: (a*wa -/+ b*wb), rounded half up
    // and rescaled from Q1.(NBT-1) back to integer.
    function automatic logic [WI-1:0] mac_rnd(
        input logic [WI-1:0]  a,
        input logic [WI-1:0]  b,
        input logic [NBT-1:0] wa,
        input logic [NBT-1:0] wb,
        input logic           sub
    );
        logic signed [WP-1:0] pa;
        logic signed [WP-1:0] pb;
        logic signed [WP-1:0] acc;
        pa  = ext_p(a) * ext_w(wa);
        pb  = ext_p(b) * ext_w(wb);
        acc = (sub ? (pa - pb) : (pa + pb)) + RND;
        acc = acc >>> (NBT - 1);
        return acc[WI-1:0];
    endfunction

    // Returns {saturated, value}: optional halving (round half up), then clamp.
    function automatic logic [NBD:0] finish_comp(input logic [WI-1:0] v, input logic scale);
        logic signed [WI-1:0] s;
        s = v;
        if (scale) begin
            s = s + ONE;
            s = s >>> 1;
        end
        if (s > MAXV) begin
            return {1'b1, MAXV[NBD-1:0]};
        end else if (s < MINV) begin
            return {1'b1, MINV[NBD-1:0]};
        end
        return {1'b0, s[NBD-1:0]};
    endfunction

    logic en;

    // Stage 1: registered inputs
    logic           v1_q, v1_d;
    logic           mode1_q, scale1_q;
    logic [NBD-1:0] xr1_q, xi1_q, yr1_q, yi1_q;
    logic [NBT-1:0] wr1_q, wi1_q;

    // Stage 2: (a, b) = (x, W*y) for DIT or (x+y, x-y) for DIF
    logic           v2_q, v2_d;
    logic           mode2_q, scale2_q;
    logic [WI-1:0]  ar2_q, ai2_q, br2_q, bi2_q;
    logic [WI-1:0]  ar2_d, ai2_d, br2_d, bi2_d;
    logic [NBT-1:0] wr2_q, wi2_q;

    // Stage 3: output registers
    logic           v3_q, v3_d;
    logic [NBD-1:0] xr3_q, xi3_q, yr3_q, yi3_q;
    logic [NBD-1:0] xr3_d, xi3_d, yr3_d, yi3_d;
    logic           sat3_q, sat3_d;
    logic           sticky_q, sticky_d;

    assign en         = ~v3_q | i_ready;
    assign o_in_ready = en & ~rst;
    assign v1_d       = i_valid & o_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q     <= 1'b0;
            mode1_q  <= 1'b0;
            scale1_q <= 1'b0;
            xr1_q    <= '0;
            xi1_q    <= '0;
            yr1_q    <= '0;
            yi1_q    <= '0;
            wr1_q    <= '0;
            wi1_q    <= '0;
        end else if (en) begin
            v1_q     <= v1_d;
            mode1_q  <= i_mode;
            scale1_q <= i_scale;
            xr1_q    <= i_x_real;
            xi1_q    <= i_x_imag;
            yr1_q    <= i_y_real;
            yi1_q    <= i_y_imag;
            wr1_q    <= i_twiddle_real;
            wi1_q    <= i_twiddle_imag;
        end
    end

    always_comb begin
        logic [WI-1:0] xr_e, xi_e, yr_e, yi_e;
        xr_e  = ext_d(xr1_q);
        xi_e  = ext_d(xi1_q);
        yr_e  = ext_d(yr1_q);
        yi_e  = ext_d(yi1_q);
        v2_d  = v1_q;
        ar2_d = xr_e;
        ai2_d = xi_e;
        br2_d = xr_e - yr_e;
        bi2_d = xi_e - yi_e;
        if (!mode1_q) begin
            br2_d = mac_rnd(yr_e, yi_e, wr1_q, wi1_q, 1'b1);
            bi2_d = mac_rnd(yr_e, yi_e, wi1_q, wr1_q, 1'b0);
        end else begin
            ar2_d = xr_e + yr_e;
            ai2_d = xi_e + yi_e;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q     <= 1'b0;
            mode2_q  <= 1'b0;
            scale2_q <= 1'b0;
            ar2_q    <= '0;
            ai2_q    <= '0;
            br2_q    <= '0;
            bi2_q    <= '0;
            wr2_q    <= '0;
            wi2_q    <= '0;
        end else if (en) begin
            v2_q     <= v2_d;
            mode2_q  <= mode1_q;
            scale2_q <= scale1_q;
            ar2_q    <= ar2_d;
            ai2_q    <= ai2_d;
            br2_q    <= br2_d;
            bi2_q    <= bi2_d;
            wr2_q    <= wr1_q;
            wi2_q    <= wi1_q;
        end
    end

    always_comb begin
        logic [WI-1:0] xr_f, xi_f, yr_f, yi_f;
        logic [NBD:0]  fxr, fxi, fyr, fyi;
        v3_d = v2_q;
        xr_f = ar2_q + br2_q;
        xi_f = ai2_q + bi2_q;
        yr_f = ar2_q - br2_q;
        yi_f = ai2_q - bi2_q;
        if (mode2_q) begin
            xr_f = ar2_q;
            xi_f = ai2_q;
            yr_f = mac_rnd(br2_q, bi2_q, wr2_q, wi2_q, 1'b1);
            yi_f = mac_rnd(br2_q, bi2_q, wi2_q, wr2_q, 1'b0);
        end
        fxr    = finish_comp(xr_f, scale2_q);
        fxi    = finish_comp(xi_f, scale2_q);
        fyr    = finish_comp(yr_f, scale2_q);
        fyi    = finish_comp(yi_f, scale2_q);
        xr3_d  = fxr[NBD-1:0];
        xi3_d  = fxi[NBD-1:0];
        yr3_d  = fyr[NBD-1:0];
        yi3_d  = fyi[NBD-1:0];
        sat3_d = fxr[NBD] | fxi[NBD] | fyr[NBD] | fyi[NBD];
        // Sticky rises on the same edge the saturating beat is presented; set beats clear.
        sticky_d = (en & v2_q & sat3_d) | (sticky_q & ~i_sat_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v3_q     <= 1'b0;
            xr3_q    <= '0;
            xi3_q    <= '0;
            yr3_q    <= '0;
            yi3_q    <= '0;
            sat3_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
            if (en) begin
                v3_q   <= v3_d;
                xr3_q  <= xr3_d;
                xi3_q  <= xi3_d;
                yr3_q  <= yr3_d;
                yi3_q  <= yi3_d;
                sat3_q <= sat3_d;
            end
        end
    end

    assign o_valid      = v3_q;
    assign o_x_real     = xr3_q;
    assign o_x_imag     = xi3_q;
    assign o_y_real     = yr3_q;
    assign o_y_imag     = yi3_q;
    assign o_sat        = sat3_q;
    assign o_sat_sticky = sticky_q;

endmodule
